dmem_responder: RTL and testbench

- Data-memory slave that answers the core's load/store requests over a valid/ready request channel and a valid/ready response channel.
- Owns a word-organised RAM and performs byte, halfword and word accesses, including lane steering, sign/zero extension and alignment/range checking.
- A programmable wait-state count models a slow memory, so the pipeline's stall path can be exercised.

---
 rtl/dmem_responder.sv | 193 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: serves byte/half/word loads and stores from a
// word-organised RAM over valid/ready request and response channels, with a
// programmable number of wait states between request acceptance and response.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt;
    logic       accept, exec;

    // Request captured at acceptance; the bus may change freely afterwards.
    logic        l_write, l_unsigned;
    logic [31:0] l_addr, l_wdata;
    logic [1:0]  l_size;

    // Request being executed: live bus when executing on the accept edge
    // (zero wait states), latched copy otherwise.
    logic        e_write, e_unsigned, e_err;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_size;

    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word, load_data, wr_data;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [3:0]    be;
    logic          mem_we;

    logic [31:0] mem [DEPTH];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic plus handshake and execute strobes.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        exec      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LAT == 4'd0) begin
                        exec      = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    exec      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // Select the request being executed and decode errors, lanes and load data.
    always_comb begin
        if (state == IDLE) begin
            e_write    = req_write;
            e_addr     = req_addr;
            e_wdata    = req_wdata;
            e_size     = req_size;
            e_unsigned = req_unsigned;
        end else begin
            e_write    = l_write;
            e_addr     = l_addr;
            e_wdata    = l_wdata;
            e_size     = l_size;
            e_unsigned = l_unsigned;
        end

        e_err = (e_size == 2'd3)
              | ((e_size == 2'd1) && e_addr[0])
              | ((e_size == 2'd2) && (e_addr[1:0] != 2'd0))
              | ({1'b0, e_addr} >= LIMIT);

        word_idx = e_addr[AW+1:2];
        rd_word  = mem[word_idx];

        case (e_addr[1:0])
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = e_addr[1] ? rd_word[31:16] : rd_word[15:0];

        case (e_size)
            2'd0: begin
                load_data = {{24{~e_unsigned & byte_sel[7]}}, byte_sel};
                be        = 4'b0001 << e_addr[1:0];
                wr_data   = {4{e_wdata[7:0]}};
            end
            2'd1: begin
                load_data = {{16{~e_unsigned & half_sel[15]}}, half_sel};
                be        = e_addr[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{e_wdata[15:0]}};
            end
            default: begin
                load_data = rd_word;
                be        = 4'b1111;
                wr_data   = e_wdata;
            end
        endcase

        mem_we = exec & e_write & ~e_err;
    end

    // RAM write port: only enabled byte lanes are updated.
    // NOTE: the RAM array has no reset; clearing it would forbid block-RAM
    // mapping and contents are undefined until written anyway.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // Request latch, wait counter and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= 4'd0;
            l_write    <= 1'b0;
            l_addr     <= 32'd0;
            l_wdata    <= 32'd0;
            l_size     <= 2'd0;
            l_unsigned <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                cnt        <= LAT;
                l_write    <= req_write;
                l_addr     <= req_addr;
                l_wdata    <= req_wdata;
                l_size     <= req_size;
                l_unsigned <= req_unsigned;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (exec) begin
                rsp_rdata <= (e_write || e_err) ? 32'd0 : load_data;
                rsp_err   <= e_err;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata <= 32'd0;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table on a 2-wait-state
// instance, hand-written backpressure and reset sequences, and a
// zero-wait-state instance streaming back-to-back requests.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;

    // Two-wait-state instance.
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    // Zero-wait-state instance.
    logic        z_req_valid, z_req_ready, z_req_write, z_req_unsigned;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [1:0]  z_req_size;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
    logic [31:0] z_rsp_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_size(z_req_size),
        .req_unsigned(z_req_unsigned),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
        .rsp_err(z_rsp_err), .busy(z_busy)
    );

    typedef struct {
        string       name;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic u, input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = name; v.write = w; v.addr = a; v.wdata = d; v.size = s; v.uns = u;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    // One complete transaction on the two-wait-state instance; returns the
    // response and the number of cycles from acceptance to rsp_valid.
    // Called just after a rising edge; returns just after the handshake edge.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic u,
                          output logic [31:0] rd, output logic er, output int lat);
        int guard;
        req_write = w; req_addr = a; req_wdata = d; req_size = s; req_unsigned = u;
        req_valid = 1'b1; rsp_ready = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble the bus after acceptance: it must have no effect.
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = ~d;
        req_size = 2'd3; req_write = ~w; req_unsigned = ~u;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 50);
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0; rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0;
        z_req_size = 2'd0; z_req_unsigned = 1'b0; z_rsp_ready = 1'b0;

        // Reset state.
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_z_req_ready", 32'(z_req_ready), 32'd1);
        check("rst_z_rsp_valid", 32'(z_rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // name, write, addr, wdata, size, unsigned, exp_rdata, exp_err
        add("sw_deadbeef",  1, 32'h10,  32'hDEADBEEF, 2, 0, 32'h0,        0);
        add("lw_10",        0, 32'h10,  32'h0,        2, 0, 32'hDEADBEEF, 0);
        add("sb_13",        1, 32'h13,  32'hAAAAAA5A, 0, 0, 32'h0,        0);
        add("lw_10_b",      0, 32'h10,  32'h0,        2, 0, 32'h5AADBEEF, 0);
        add("lb_13",        0, 32'h13,  32'h0,        0, 0, 32'h0000005A, 0);
        add("lh_12",        0, 32'h12,  32'h0,        1, 0, 32'h00005AAD, 0);
        add("lh_10",        0, 32'h10,  32'h0,        1, 0, 32'hFFFFBEEF, 0);
        add("lhu_10",       0, 32'h10,  32'h0,        1, 1, 32'h0000BEEF, 0);
        add("lb_10",        0, 32'h10,  32'h0,        0, 0, 32'hFFFFFFEF, 0);
        add("lbu_11",       0, 32'h11,  32'h0,        0, 1, 32'h000000BE, 0);
        add("lb_12",        0, 32'h12,  32'h0,        0, 0, 32'hFFFFFFAD, 0);
        add("lw_mis_12",    0, 32'h12,  32'h0,        2, 0, 32'h0,        1);
        add("sh_mis_11",    1, 32'h11,  32'hFFFFFFFF, 1, 0, 32'h0,        1);
        add("lw_10_kept",   0, 32'h10,  32'h0,        2, 0, 32'h5AADBEEF, 0);
        add("lw_oor",       0, 32'h1000, 32'h0,       2, 0, 32'h0,        1);
        add("lw_size3",     0, 32'h10,  32'h0,        3, 0, 32'h0,        1);
        add("sw_oor",       1, 32'h1000, 32'h0,       2, 0, 32'h0,        1);
        add("lw_high",      0, 32'hFFFFFFFC, 32'h0,   2, 0, 32'h0,        1);
        add("sh_12",        1, 32'h12,  32'hABCD1234, 1, 0, 32'h0,        0);
        add("lw_10_c",      0, 32'h10,  32'h0,        2, 0, 32'h1234BEEF, 0);
        add("sb_11",        1, 32'h11,  32'hFFFFFF80, 0, 0, 32'h0,        0);
        add("lb_11",        0, 32'h11,  32'h0,        0, 0, 32'hFFFFFF80, 0);
        add("lw_10_d",      0, 32'h10,  32'h0,        2, 0, 32'h123480EF, 0);
        add("sw_last",      1, 32'hFFC, 32'hCAFEF00D, 2, 0, 32'h0,        0);
        add("lw_last",      0, 32'hFFC, 32'h0,        2, 0, 32'hCAFEF00D, 0);
        add("lh_ffe",       0, 32'hFFE, 32'h0,        1, 0, 32'hFFFFCAFE, 0);
        add("lhu_ffe",      0, 32'hFFE, 32'h0,        1, 1, 32'h0000CAFE, 0);
        add("lbu_ffc",      0, 32'hFFC, 32'h0,        0, 1, 32'h0000000D, 0);
        add("lh_mis_fff",   0, 32'hFFF, 32'h0,        1, 0, 32'h0,        1);

        foreach (vecs[i]) begin
            do_req(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, rd, er, lat);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_latency"}, 32'(lat), 32'd3);
        end

        // Backpressure: response held for 5 cycles, a request pulse ignored.
        req_write = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 50);
        check("bp_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            req_valid = (i < 2); req_write = 1'b1; req_addr = 32'h10;
            req_wdata = 32'h0; req_size = 2'd2;
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'h123480EF);
            check("bp_rsp_err", 32'(rsp_err), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er, lat);
        check("bp_ignored_store", rd, 32'h123480EF);

        // Reset during WAIT aborts a pending store.
        do_req(1'b1, 32'h20, 32'h0, 2'd2, 1'b0, rd, er, lat);
        check("clr_20_err", 32'(er), 32'd0);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 2'd2;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        check("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, rd, er, lat);
        check("mid_rst_aborted", rd, 32'h0);
        check("mid_rst_load_err", 32'(er), 32'd0);

        // Zero wait states: store then back-to-back loads, one response every 2 cycles.
        z_req_write = 1'b1; z_req_addr = 32'h0; z_req_wdata = 32'h11223344;
        z_req_size = 2'd2; z_req_unsigned = 1'b0; z_rsp_ready = 1'b1; z_req_valid = 1'b1;
        @(posedge clk);
        #1;
        z_req_write = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("z_rsp_valid", 32'(z_rsp_valid), 32'((i % 2) == 0));
            check("z_req_ready", 32'(z_req_ready), 32'((i % 2) != 0));
            if ((i % 2) == 0) begin
                check("z_rsp_rdata", z_rsp_rdata, (i == 0) ? 32'h0 : 32'h11223344);
                check("z_rsp_err", 32'(z_rsp_err), 32'd0);
            end
        end
        z_req_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
